// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the machine CSR file: records mepc/mcause on an
// exception, redirects to mtvec, returns via mepc on mret, else passes software CSR accesses.
module trap_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_trap_req,
    input  logic [DATA_WIDTH-1:0] i_trap_pc,
    input  logic [DATA_WIDTH-1:0] i_trap_cause,
    input  logic                  i_mret,
    input  logic                  i_sw_we,
    input  logic [ADDR_WIDTH-1:0] i_sw_addr,
    input  logic [DATA_WIDTH-1:0] i_sw_wdata,
    output logic [DATA_WIDTH-1:0] o_sw_rdata,
    output logic                  o_csr_write_en,
    output logic [ADDR_WIDTH-1:0] o_csr_write_addr,
    output logic [DATA_WIDTH-1:0] o_csr_write_data,
    output logic [ADDR_WIDTH-1:0] o_csr_read_addr,
    input  logic [DATA_WIDTH-1:0] i_csr_read_data,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTVEC  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RSVD   = ADDR_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_EPC   = 3'd1,
        WR_CAUSE = 3'd2,
        TRAP_JMP = 3'd3,
        RET_JMP  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] cause_q;

    // Only direct vector mode exists, so the low two bits of a target are dropped.
    function automatic logic [DATA_WIDTH-1:0] align4(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

    // State register and the trap context captured when a trap is accepted.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r <= IDLE;
            pc_q    <= {DATA_WIDTH{1'b0}};
            cause_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == IDLE && i_trap_req) begin
                pc_q    <= i_trap_pc;
                cause_q <= i_trap_cause;
            end else begin
                pc_q    <= pc_q;
                cause_q <= cause_q;
            end
        end
    end

    // Next-state selection and all CSR/redirect outputs.
    always_comb begin
        state_next_s     = state_r;
        o_csr_write_en   = 1'b0;
        o_csr_write_addr = ADDR_MEPC;
        o_csr_write_data = {DATA_WIDTH{1'b0}};
        o_csr_read_addr  = ADDR_MEPC;
        o_sw_rdata       = {DATA_WIDTH{1'b0}};
        o_redirect_valid = 1'b0;
        o_redirect_pc    = {DATA_WIDTH{1'b0}};
        o_busy           = 1'b1;
        case (state_r)
            IDLE: begin
                o_busy          = 1'b0;
                o_csr_read_addr = i_sw_addr;
                o_sw_rdata      = i_csr_read_data;
                if (i_trap_req) begin
                    state_next_s = WR_EPC;
                end else if (i_mret) begin
                    state_next_s = RET_JMP;
                end else begin
                    // Reserved address has no backing register; such writes vanish.
                    o_csr_write_en   = i_sw_we && (i_sw_addr != ADDR_RSVD);
                    o_csr_write_addr = i_sw_addr;
                    o_csr_write_data = i_sw_wdata;
                    state_next_s     = IDLE;
                end
            end
            WR_EPC: begin
                o_csr_write_en   = 1'b1;
                o_csr_write_addr = ADDR_MEPC;
                o_csr_write_data = pc_q;
                state_next_s     = WR_CAUSE;
            end
            WR_CAUSE: begin
                o_csr_write_en   = 1'b1;
                o_csr_write_addr = ADDR_MCAUSE;
                o_csr_write_data = cause_q;
                state_next_s     = TRAP_JMP;
            end
            TRAP_JMP: begin
                o_csr_read_addr  = ADDR_MTVEC;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = align4(i_csr_read_data);
                state_next_s     = IDLE;
            end
            RET_JMP: begin
                o_csr_read_addr  = ADDR_MEPC;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = align4(i_csr_read_data);
                state_next_s     = IDLE;
            end
            default: begin
                o_busy       = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a behavioural CSR file is attached to the
// DUT and a reference array of expected CSR contents predicts every observation.
module tb_trap_ctrl;
    localparam int DW = 64;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          arstn;
    logic          trap_req, mret, sw_we;
    logic [DW-1:0] trap_pc, trap_cause, sw_wdata, sw_rdata;
    logic [AW-1:0] sw_addr, csr_write_addr, csr_read_addr;
    logic          csr_write_en, redirect_valid, busy;
    logic [DW-1:0] csr_write_data, csr_read_data, redirect_pc;

    logic [DW-1:0] csr_mem [4];
    logic [DW-1:0] model [4];
    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .arstn(arstn),
        .i_trap_req(trap_req), .i_trap_pc(trap_pc), .i_trap_cause(trap_cause),
        .i_mret(mret), .i_sw_we(sw_we), .i_sw_addr(sw_addr), .i_sw_wdata(sw_wdata),
        .o_sw_rdata(sw_rdata), .o_csr_write_en(csr_write_en),
        .o_csr_write_addr(csr_write_addr), .o_csr_write_data(csr_write_data),
        .o_csr_read_addr(csr_read_addr), .i_csr_read_data(csr_read_data),
        .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc), .o_busy(busy)
    );

    // Behavioural CSR file: synchronous write, combinational read, no reset.
    always @(posedge clk) if (csr_write_en) csr_mem[csr_write_addr] <= csr_write_data;
    assign csr_read_data = csr_mem[csr_read_addr];

    function automatic logic [DW-1:0] masked(input logic [DW-1:0] v);
        return v & ~64'h3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        trap_req = 1'b0; mret = 1'b0; sw_we = 1'b0; sw_addr = 2'd0;
        sw_wdata = 64'd0; trap_pc = 64'd0; trap_cause = 64'd0;
    endtask

    task automatic sw_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sw_we = 1'b1; sw_addr = a; sw_wdata = d;
        #1;
        n_run++; if (csr_write_en !== (a != 2'd3)) begin n_fail++; $display("FAIL sw_we addr=%0d got %b exp %b", a, csr_write_en, (a != 2'd3)); end
        if (a != 2'd3) begin
            n_run++; if (csr_write_addr !== a || csr_write_data !== d) begin n_fail++; $display("FAIL sw_wport got %0d/%h exp %0d/%h", csr_write_addr, csr_write_data, a, d); end
        end
        tick;
        sw_we = 1'b0;
        if (a != 2'd3) model[a] = d;
    endtask

    task automatic sw_read(input logic [AW-1:0] a);
        sw_addr = a;
        #1;
        n_run++; if (sw_rdata !== model[a]) begin n_fail++; $display("FAIL sw_read addr=%0d got %h exp %h", a, sw_rdata, model[a]); end
    endtask

    // Drive junk on the request inputs while busy; it must have no effect.
    task automatic noise(input bit en);
        trap_req = en ? 1'($urandom_range(0, 1)) : 1'b0;
        mret     = en ? 1'($urandom_range(0, 1)) : 1'b0;
        sw_we    = en ? 1'($urandom_range(0, 1)) : 1'b0;
        sw_addr  = 2'd2;
        sw_wdata = {$urandom, $urandom};
        trap_pc  = {$urandom, $urandom};
        trap_cause = {$urandom, $urandom};
    endtask

    task automatic do_trap(input logic [DW-1:0] pc, input logic [DW-1:0] cause, input bit en_noise, input bit combo);
        trap_req = 1'b1; trap_pc = pc; trap_cause = cause;
        mret = combo; sw_we = combo; sw_addr = 2'd2; sw_wdata = 64'hDEAD;
        #1;
        n_run++; if (busy !== 1'b0 || csr_write_en !== 1'b0) begin n_fail++; $display("FAIL trap_accept busy/we got %b/%b exp 0/0", busy, csr_write_en); end
        tick;
        noise(en_noise);
        #1;
        n_run++; if (busy !== 1'b1 || sw_rdata !== 64'd0) begin n_fail++; $display("FAIL wr_epc busy/rdata got %b/%h exp 1/0", busy, sw_rdata); end
        n_run++; if (csr_write_en !== 1'b1 || csr_write_addr !== 2'd0 || csr_write_data !== pc) begin n_fail++; $display("FAIL wr_epc got %b/%0d/%h exp 1/0/%h", csr_write_en, csr_write_addr, csr_write_data, pc); end
        n_run++; if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin n_fail++; $display("FAIL wr_epc redirect got %b/%h exp 0/0", redirect_valid, redirect_pc); end
        tick;
        model[0] = pc;
        noise(en_noise);
        #1;
        n_run++; if (csr_mem[0] !== model[0]) begin n_fail++; $display("FAIL mepc_written got %h exp %h", csr_mem[0], model[0]); end
        n_run++; if (busy !== 1'b1 || csr_write_en !== 1'b1 || csr_write_addr !== 2'd1 || csr_write_data !== cause) begin n_fail++; $display("FAIL wr_cause got %b/%b/%0d/%h exp 1/1/1/%h", busy, csr_write_en, csr_write_addr, csr_write_data, cause); end
        n_run++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL wr_cause redirect got %b exp 0", redirect_valid); end
        tick;
        model[1] = cause;
        idle_inputs;
        #1;
        n_run++; if (busy !== 1'b1 || csr_write_en !== 1'b0 || csr_read_addr !== 2'd2) begin n_fail++; $display("FAIL trap_jmp busy/we/raddr got %b/%b/%0d exp 1/0/2", busy, csr_write_en, csr_read_addr); end
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== masked(model[2])) begin n_fail++; $display("FAIL trap_redirect got %b/%h exp 1/%h", redirect_valid, redirect_pc, masked(model[2])); end
        tick;
        n_run++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin n_fail++; $display("FAIL trap_done got %b/%b/%h exp 0/0/0", busy, redirect_valid, redirect_pc); end
        n_run++; if (csr_mem[0] !== model[0] || csr_mem[1] !== model[1] || csr_mem[2] !== model[2]) begin n_fail++; $display("FAIL trap_csrs got %h/%h/%h exp %h/%h/%h", csr_mem[0], csr_mem[1], csr_mem[2], model[0], model[1], model[2]); end
    endtask

    task automatic do_mret;
        mret = 1'b1; sw_we = 1'b1; sw_addr = 2'd2; sw_wdata = {$urandom, $urandom};
        #1;
        n_run++; if (busy !== 1'b0 || csr_write_en !== 1'b0) begin n_fail++; $display("FAIL mret_accept busy/we got %b/%b exp 0/0", busy, csr_write_en); end
        tick;
        idle_inputs;
        #1;
        n_run++; if (busy !== 1'b1 || csr_write_en !== 1'b0 || csr_read_addr !== 2'd0) begin n_fail++; $display("FAIL ret_jmp busy/we/raddr got %b/%b/%0d exp 1/0/0", busy, csr_write_en, csr_read_addr); end
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== masked(model[0])) begin n_fail++; $display("FAIL mret_redirect got %b/%h exp 1/%h", redirect_valid, redirect_pc, masked(model[0])); end
        tick;
        n_run++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || csr_mem[2] !== model[2]) begin n_fail++; $display("FAIL mret_done got %b/%b/%h exp 0/0/%h", busy, redirect_valid, csr_mem[2], model[2]); end
    endtask

    task automatic test_reset;
        idle_inputs;
        arstn = 1'b0;
        #2;
        n_run++; if (busy !== 1'b0 || csr_write_en !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin n_fail++; $display("FAIL reset got %b/%b/%b/%h exp 0/0/0/0", busy, csr_write_en, redirect_valid, redirect_pc); end
        tick;
        arstn = 1'b1;
        tick;
    endtask

    task automatic test_sw_access;
        for (int i = 0; i < 3; i++) sw_write(AW'(i), {$urandom, $urandom});
        sw_write(2'd3, 64'h1234);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) sw_write(AW'($urandom_range(0, 3)), {$urandom, $urandom});
            sw_read(AW'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_directed_trap;
        sw_write(2'd2, 64'h8000_0000);
        do_trap(64'h1000, 64'd2, 1'b0, 1'b0);
        sw_write(2'd2, 64'h8000_0003);
        do_trap(64'h1000, 64'd2, 1'b1, 1'b0);
        do_mret;
        sw_read(2'd1);
    endtask

    task automatic test_same_cycle;
        do_trap({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back;
        do_trap({$urandom, $urandom}, 64'd5, 1'b0, 1'b0);
        do_trap({$urandom, $urandom}, 64'd7, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] pc;
        pc = {$urandom, $urandom};
        trap_req = 1'b1; trap_pc = pc; trap_cause = 64'hBAD;
        tick;
        idle_inputs;
        tick;
        model[0] = pc;
        arstn = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0 || csr_write_en !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin n_fail++; $display("FAIL midreset got %b/%b/%b/%h exp 0/0/0/0", busy, csr_write_en, redirect_valid, redirect_pc); end
        tick;
        tick;
        arstn = 1'b1;
        n_run++; if (csr_mem[0] !== model[0] || csr_mem[1] !== model[1] || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_csrs got %h/%h/%b exp %h/%h/0", csr_mem[0], csr_mem[1], redirect_valid, model[0], model[1]); end
        tick;
        do_trap({$urandom, $urandom}, 64'd11, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: do_trap({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'($urandom_range(0, 1)));
                1: do_mret;
                2: sw_write(AW'($urandom_range(0, 3)), {$urandom, $urandom});
                default: sw_read(AW'($urandom_range(0, 2)));
            endcase
        end
    endtask

    initial begin
        test_reset;
        test_sw_access;
        test_directed_trap;
        test_same_cycle;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the machine CSR file (mepc = addr 0, mcause = addr 1, mtvec = addr 2, addr 3 reserved).
- Owns the CSR file's single write port and its read address.
- On an exception, it writes mepc and then mcause, reads mtvec and issues a PC redirect.
- On mret, it reads mepc and issues a redirect. In idle, it passes software CSR accesses through.

Parameters:
- DATA_WIDTH, 64, width of PC, cause and CSR data.
- ADDR_WIDTH, 2, CSR file address width.

Ports:
- clk  input  1  clock.
- arstn  input  1  reset, asynchronous, active-low.
- i_trap_req  input  1  exception request from the execute stage.
- i_trap_pc  input  DATA_WIDTH  PC of the faulting instruction.
- i_trap_cause  input  DATA_WIDTH  mcause value.
- i_mret  input  1  mret retiring.
- i_sw_we  input  1  software CSR write request.
- i_sw_addr  input  ADDR_WIDTH  software CSR address (read and write).
- i_sw_wdata  input  DATA_WIDTH  software CSR write data.
- o_sw_rdata  output  DATA_WIDTH  software CSR read data.
- o_csr_write_en  output  1  to CSR file write_en.
- o_csr_write_addr  output  ADDR_WIDTH  to CSR file write address.
- o_csr_write_data  output  DATA_WIDTH  to CSR file write data.
- o_csr_read_addr  output  ADDR_WIDTH  to CSR file read address.
- i_csr_read_data  input  DATA_WIDTH  from CSR file read data (combinational).
- o_redirect_valid  output  1  one-cycle PC redirect strobe.
- o_redirect_pc  output  DATA_WIDTH  redirect target.
- o_busy  output  1  high whenever state is not IDLE; the pipeline stalls on it.

Behaviour:
- States: IDLE, WR_EPC, WR_CAUSE, TRAP_JMP, RET_JMP. State register plus pc_q and cause_q are flops.
- Reset (async, any time, including mid-sequence):
  - state goes to IDLE; pc_q and cause_q clear to 0.
  - Outputs after reset: o_csr_write_en=0, o_redirect_valid=0, o_busy=0, o_redirect_pc=0.
  - A partially written trap is abandoned, with no further writes.
- IDLE priority (sampled at the clock edge):
  - i_trap_req is highest: latch pc_q=i_trap_pc and cause_q=i_trap_cause, go to WR_EPC.
  - Else i_mret: go to RET_JMP.
  - Else software passthrough, combinational in the same cycle:
    - o_csr_write_en = i_sw_we AND (i_sw_addr != 3); writes to reserved addr 3 are dropped.
    - o_csr_write_addr = i_sw_addr; o_csr_write_data = i_sw_wdata.
  - Software writes in the same cycle as a trap or mret are suppressed.
- Software read path:
  - In IDLE, o_csr_read_addr = i_sw_addr and o_sw_rdata = i_csr_read_data.
  - o_sw_rdata = 0 when not in IDLE.
- WR_EPC: write_en=1, addr=0, data=pc_q. Next state WR_CAUSE.
- WR_CAUSE: write_en=1, addr=1, data=cause_q. Next state TRAP_JMP.
- TRAP_JMP:
  - read_addr=2, write_en=0.
  - o_redirect_valid=1; o_redirect_pc = i_csr_read_data with bits[1:0] forced to 0 (direct mode only).
  - Next state IDLE.
- RET_JMP:
  - read_addr=0.
  - o_redirect_valid=1; o_redirect_pc = i_csr_read_data with bits[1:0] forced to 0.
  - Next state IDLE.
- Latency, with request accepted at edge T:
  - Trap: mepc written at edge T+1, mcause at T+2, redirect valid in cycle T+3.
  - mret: redirect valid in cycle T+1.
- o_busy is high in every non-IDLE state. i_trap_req, i_mret and i_sw_we are ignored while busy, with no queuing; requesters must hold or re-issue.
- Outside TRAP_JMP and RET_JMP, o_redirect_valid=0 and o_redirect_pc=0.
- Outside IDLE, o_csr_read_addr=2 in TRAP_JMP, 0 in RET_JMP, and 0 otherwise.
- Back-to-back: a trap asserted in the cycle after TRAP_JMP (state already IDLE) is accepted normally.

Test Plan:
- Reset, then mtvec=0x8000_0000 via software write, then trap pc=0x1000, cause=2 → mepc=0x1000 at T+1, mcause=2 at T+2, redirect_valid with pc=0x8000_0000 at T+3, busy high for 3 cycles.
- Set mtvec=0x8000_0003, then trap → redirect pc=0x8000_0000 (low bits masked).
- After a trap, mret → redirect_valid at T+1 with pc=0x1000; no CSR writes.
- Trap, mret and sw write (addr 2, data 0xDEAD) in the same IDLE cycle → trap sequence runs, mtvec unchanged, mret ignored.
- Software write to addr 3 → o_csr_write_en stays 0; software read of addr 1 in IDLE returns mcause combinationally.
- arstn low during WR_CAUSE → immediately IDLE, outputs 0, mcause not written, no redirect; a new trap after reset completes normally.
